// File: rtl/pipeline_debug_sequencer.sv
// Run/step/halt debug sequencer for the 5-stage MIPS pipeline.
// Gates the PC and pipeline-register enables. When HALT is seen in ID, it drains
// the in-flight instructions. It then serially dumps PC, the register file and
// data memory to the UART TX path over a valid/ready handshake.
//
// Optional feature: define DBG_CYCLE_COUNT_EN to add a saturating 32-bit count
// of pipeline-enabled cycles. Its value is appended as the final dump word.
//
// Ports:
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_cmd, i_cmd_valid      debug command (00 NOP, 01 RUN, 10 STEP, 11 DUMP)
//   o_cmd_ready             command accepted when valid && ready
//   i_halt_id               HALT opcode decoded in ID
//   i_pc                    current PC, captured at dump start
//   o_pc_en, o_pipe_en      PC / pipeline-register enables
//   o_halted                program finished and pipeline drained (sticky)
//   o_reg_rd_addr/i_reg_rd_data  register-file debug read port (1-cycle latency)
//   o_mem_rd_addr/i_mem_rd_data  data-memory debug read port (1-cycle latency)
//   o_tx_data, o_tx_valid, i_tx_ready  dump word stream
module pipeline_debug_sequencer #(
  parameter int unsigned NB_DATA      = 32,
  parameter int unsigned NB_REG_ADDR  = 5,
  parameter int unsigned N_REGS       = 32,
  parameter int unsigned NB_MEM_ADDR  = 8,
  parameter int unsigned MEM_WORDS    = 32,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [1:0]             i_cmd,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic                   i_halt_id,
  input  logic [NB_DATA-1:0]     i_pc,
  output logic                   o_pc_en,
  output logic                   o_pipe_en,
  output logic                   o_halted,
  output logic [NB_REG_ADDR-1:0] o_reg_rd_addr,
  input  logic [NB_DATA-1:0]     i_reg_rd_data,
  output logic [NB_MEM_ADDR-1:0] o_mem_rd_addr,
  input  logic [NB_DATA-1:0]     i_mem_rd_data,
  output logic [NB_DATA-1:0]     o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready
);

`ifdef DBG_CYCLE_COUNT_EN
  localparam int unsigned N_CNT_WORDS = 1;
`else
  localparam int unsigned N_CNT_WORDS = 0;
`endif
  localparam int unsigned N_WORDS  = 1 + N_REGS + MEM_WORDS + N_CNT_WORDS;
  localparam int unsigned NB_IDX   = $clog2(N_WORDS + 1);
  localparam int unsigned NB_DRAIN = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  // Dump index map: 0 = PC, 1..N_REGS = registers, then memory, then counter.
  localparam logic [NB_IDX-1:0]   IDX_REG_LAST = NB_IDX'(N_REGS);
  localparam logic [NB_IDX-1:0]   IDX_MEM_LAST = NB_IDX'(N_REGS + MEM_WORDS);
  localparam logic [NB_IDX-1:0]   IDX_LAST     = NB_IDX'(N_WORDS - 1);
  localparam logic [NB_DRAIN-1:0] DRAIN_LOAD   = NB_DRAIN'(DRAIN_CYCLES - 1);

  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_DUMP = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_DRAIN,
    S_HALTED,
    S_DUMP_ADDR,
    S_DUMP_WAIT,
    S_DUMP_SEND
  } state_e;

  state_e                 state_q, state_d;
  logic                   ret_halted_q, ret_halted_d;
  logic [NB_DRAIN-1:0]    drain_cnt_q, drain_cnt_d;
  logic [NB_IDX-1:0]      idx_q, idx_d;
  logic [NB_DATA-1:0]     pc_cap_q, pc_cap_d;
  logic [NB_DATA-1:0]     tx_data_q, tx_data_d;
  logic                   tx_valid_q, tx_valid_d;
  logic                   pc_en_q, pc_en_d;
  logic                   pipe_en_q, pipe_en_d;
  logic                   halted_q, halted_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic [NB_REG_ADDR-1:0] reg_addr_q, reg_addr_d;
  logic [NB_MEM_ADDR-1:0] mem_addr_q, mem_addr_d;
  logic                   cmd_fire;

`ifdef DBG_CYCLE_COUNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;

  // Saturating count of cycles with the pipeline enabled.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (pipe_en_q && (cycle_cnt_q != 32'hFFFF_FFFF)) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cycle_cnt_q <= 32'd0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
    end
  end
`endif

  assign cmd_fire = i_cmd_valid && cmd_ready_q;

  // Next-state logic. Outputs are derived from the next state so that the
  // registered outputs line up with the state they describe.
  always_comb begin
    state_d      = state_q;
    ret_halted_d = ret_halted_q;
    drain_cnt_d  = drain_cnt_q;
    idx_d        = idx_q;
    pc_cap_d     = pc_cap_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    reg_addr_d   = '0;
    mem_addr_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          case (i_cmd)
            CMD_RUN:  state_d = S_RUN;
            CMD_STEP: state_d = S_STEP;
            CMD_DUMP: begin
              state_d      = S_DUMP_ADDR;
              ret_halted_d = 1'b0;
              idx_d        = '0;
              pc_cap_d     = i_pc;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_RUN: begin
        if (i_halt_id) begin
          state_d     = S_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end
      end
      S_STEP: begin
        if (i_halt_id) begin
          state_d     = S_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d = S_HALTED;
        end else begin
          drain_cnt_d = drain_cnt_q - NB_DRAIN'(1);
        end
      end
      S_HALTED: begin
        // RUN/STEP/NOP are accepted here but have no effect.
        if (cmd_fire && (i_cmd == CMD_DUMP)) begin
          state_d      = S_DUMP_ADDR;
          ret_halted_d = 1'b1;
          idx_d        = '0;
          pc_cap_d     = i_pc;
        end
      end
      S_DUMP_ADDR: begin
        state_d = S_DUMP_WAIT;
      end
      S_DUMP_WAIT: begin
        // Read data for the address driven in DUMP_ADDR is valid now.
        tx_data_d = i_mem_rd_data;
        if (idx_q == '0) begin
          tx_data_d = pc_cap_q;
        end else if (idx_q <= IDX_REG_LAST) begin
          tx_data_d = i_reg_rd_data;
        end
`ifdef DBG_CYCLE_COUNT_EN
        else if (idx_q > IDX_MEM_LAST) begin
          tx_data_d = NB_DATA'(cycle_cnt_q);
        end
`endif
        tx_valid_d = 1'b1;
        state_d    = S_DUMP_SEND;
      end
      S_DUMP_SEND: begin
        if (i_tx_ready) begin
          tx_valid_d = 1'b0;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ret_halted_q ? S_HALTED : S_IDLE;
          end else begin
            idx_d   = idx_q + NB_IDX'(1);
            state_d = S_DUMP_ADDR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Read addresses are held across DUMP_ADDR and DUMP_WAIT only.
    if ((state_d == S_DUMP_ADDR) || (state_d == S_DUMP_WAIT)) begin
      if ((idx_d >= NB_IDX'(1)) && (idx_d <= IDX_REG_LAST)) begin
        reg_addr_d = NB_REG_ADDR'(idx_d - NB_IDX'(1));
      end else if ((idx_d > IDX_REG_LAST) && (idx_d <= IDX_MEM_LAST)) begin
        mem_addr_d = NB_MEM_ADDR'(idx_d - IDX_REG_LAST - NB_IDX'(1));
      end
    end

    pc_en_d     = (state_d == S_RUN) || (state_d == S_STEP);
    pipe_en_d   = (state_d == S_RUN) || (state_d == S_STEP) || (state_d == S_DRAIN);
    cmd_ready_d = (state_d == S_IDLE) || (state_d == S_HALTED);
    halted_d    = halted_q || (state_d == S_HALTED);
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      ret_halted_q <= 1'b0;
      drain_cnt_q  <= '0;
      idx_q        <= '0;
      pc_cap_q     <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      pc_en_q      <= 1'b0;
      pipe_en_q    <= 1'b0;
      halted_q     <= 1'b0;
      cmd_ready_q  <= 1'b1;
      reg_addr_q   <= '0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      ret_halted_q <= ret_halted_d;
      drain_cnt_q  <= drain_cnt_d;
      idx_q        <= idx_d;
      pc_cap_q     <= pc_cap_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      pc_en_q      <= pc_en_d;
      pipe_en_q    <= pipe_en_d;
      halted_q     <= halted_d;
      cmd_ready_q  <= cmd_ready_d;
      reg_addr_q   <= reg_addr_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  assign o_cmd_ready   = cmd_ready_q;
  assign o_pc_en       = pc_en_q;
  assign o_pipe_en     = pipe_en_q;
  assign o_halted      = halted_q;
  assign o_reg_rd_addr = reg_addr_q;
  assign o_mem_rd_addr = mem_addr_q;
  assign o_tx_data     = tx_data_q;
  assign o_tx_valid    = tx_valid_q;

endmodule

// File: tb/tb_pipeline_debug_sequencer.sv
// Self-checking bench for pipeline_debug_sequencer: run/halt/drain timing,
// stepping, dump contents/order, backpressure and mid-dump reset.
module tb_pipeline_debug_sequencer;

  localparam int unsigned NB_DATA     = 32;
  localparam int unsigned NB_REG_ADDR = 5;
  localparam int unsigned N_REGS      = 32;
  localparam int unsigned NB_MEM_ADDR = 8;
  localparam int unsigned MEM_WORDS   = 32;
  localparam int unsigned DRAIN       = 3;
`ifdef DBG_CYCLE_COUNT_EN
  localparam int unsigned N_WORDS = 2 + N_REGS + MEM_WORDS;
`else
  localparam int unsigned N_WORDS = 1 + N_REGS + MEM_WORDS;
`endif

  localparam logic [1:0] C_NOP  = 2'b00;
  localparam logic [1:0] C_RUN  = 2'b01;
  localparam logic [1:0] C_STEP = 2'b10;
  localparam logic [1:0] C_DUMP = 2'b11;

  logic                   i_clk;
  logic                   i_rst_n;
  logic [1:0]             i_cmd;
  logic                   i_cmd_valid;
  logic                   o_cmd_ready;
  logic                   i_halt_id;
  logic [NB_DATA-1:0]     i_pc;
  logic                   o_pc_en;
  logic                   o_pipe_en;
  logic                   o_halted;
  logic [NB_REG_ADDR-1:0] o_reg_rd_addr;
  logic [NB_DATA-1:0]     i_reg_rd_data;
  logic [NB_MEM_ADDR-1:0] o_mem_rd_addr;
  logic [NB_DATA-1:0]     i_mem_rd_data;
  logic [NB_DATA-1:0]     o_tx_data;
  logic                   o_tx_valid;
  logic                   i_tx_ready;

  logic [NB_DATA-1:0] regs [N_REGS];
  logic [NB_DATA-1:0] mem  [256];

  int checks = 0;
  int errors = 0;

  pipeline_debug_sequencer #(
    .NB_DATA(NB_DATA), .NB_REG_ADDR(NB_REG_ADDR), .N_REGS(N_REGS),
    .NB_MEM_ADDR(NB_MEM_ADDR), .MEM_WORDS(MEM_WORDS), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cmd(i_cmd), .i_cmd_valid(i_cmd_valid),
    .o_cmd_ready(o_cmd_ready), .i_halt_id(i_halt_id), .i_pc(i_pc),
    .o_pc_en(o_pc_en), .o_pipe_en(o_pipe_en), .o_halted(o_halted),
    .o_reg_rd_addr(o_reg_rd_addr), .i_reg_rd_data(i_reg_rd_data),
    .o_mem_rd_addr(o_mem_rd_addr), .i_mem_rd_data(i_mem_rd_data),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Register file and data memory with 1-cycle read latency.
  always @(posedge i_clk) begin
    i_reg_rd_data <= regs[o_reg_rd_addr];
    i_mem_rd_data <= mem[o_mem_rd_addr];
  end

`ifdef DBG_CYCLE_COUNT_EN
  logic [31:0] model_cnt;
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) model_cnt <= 32'd0;
    else if (o_pipe_en && (model_cnt != 32'hFFFF_FFFF)) model_cnt <= model_cnt + 32'd1;
  end
`endif

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_reset();
    i_rst_n = 1'b0;
    i_cmd_valid = 1'b0; i_cmd = C_NOP; i_halt_id = 1'b0; i_tx_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    tick();
  endtask

  task automatic issue_cmd(input logic [1:0] c);
    i_cmd = c;
    i_cmd_valid = 1'b1;
    tick();
    i_cmd_valid = 1'b0;
    i_cmd = C_NOP;
  endtask

  task automatic fill_pattern();
    for (int k = 0; k < int'(N_REGS); k++) regs[k] = 32'(k);
    for (int k = 0; k < 256; k++) mem[k] = 32'h100 + 32'(k);
  endtask

  task automatic fill_random();
    for (int k = 0; k < int'(N_REGS); k++) regs[k] = $urandom;
    for (int k = 0; k < 256; k++) mem[k] = $urandom;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_cmd_valid = 1'b0; i_cmd = C_NOP; i_halt_id = 1'b0; i_tx_ready = 1'b0; i_pc = '0;
    #17;
    checks++; if (o_pc_en !== 1'b0) begin errors++; $display("FAIL reset_pc_en: got %b expected 0", o_pc_en); end
    checks++; if (o_pipe_en !== 1'b0) begin errors++; $display("FAIL reset_pipe_en: got %b expected 0", o_pipe_en); end
    checks++; if (o_tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", o_tx_valid); end
    checks++; if (o_halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", o_halted); end
    checks++; if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", o_cmd_ready); end
    checks++; if (o_tx_data !== '0 || o_reg_rd_addr !== '0 || o_mem_rd_addr !== '0) begin
      errors++; $display("FAIL reset_data_addr: got data=%h ra=%h ma=%h expected all 0", o_tx_data, o_reg_rd_addr, o_mem_rd_addr);
    end
    @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    tick();
  endtask

  // RUN, HALT seen on the n-th RUN cycle; random commands while busy must be ignored.
  task automatic test_run_halt(input int n);
    int pc_cnt = 0, pipe_cnt = 0, first_halt = 0, busy_ready = 0;
    checks++; if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL run_pre_ready: got %b expected 1", o_cmd_ready); end
    issue_cmd(C_RUN);
    for (int c = 1; c <= n + int'(DRAIN) + 6; c++) begin
      if (o_pc_en) pc_cnt++;
      if (o_pipe_en) pipe_cnt++;
      if (o_halted && first_halt == 0) first_halt = c;
      if (c <= n + int'(DRAIN) && o_cmd_ready) busy_ready++;
      i_halt_id = (c == n);
      i_cmd_valid = (c <= n + int'(DRAIN)) ? (($urandom % 3) == 0) : 1'b0;
      i_cmd = 2'($urandom);
      tick();
    end
    i_halt_id = 1'b0; i_cmd_valid = 1'b0; i_cmd = C_NOP;
    checks++; if (pc_cnt != n) begin errors++; $display("FAIL run_pc_en_cycles: got %0d expected %0d", pc_cnt, n); end
    checks++; if (pipe_cnt != n + int'(DRAIN)) begin errors++; $display("FAIL run_pipe_en_cycles: got %0d expected %0d", pipe_cnt, n + int'(DRAIN)); end
    checks++; if (first_halt != n + int'(DRAIN) + 1) begin errors++; $display("FAIL run_halted_cycle: got %0d expected %0d", first_halt, n + int'(DRAIN) + 1); end
    checks++; if (busy_ready != 0) begin errors++; $display("FAIL run_busy_ready: got %0d ready cycles expected 0", busy_ready); end
    checks++; if (o_halted !== 1'b1 || o_cmd_ready !== 1'b1) begin errors++; $display("FAIL run_end_halted: got halted=%b ready=%b expected 1 1", o_halted, o_cmd_ready); end
  endtask

  // Three STEPs; i_halt_id held high while idle must be ignored.
  task automatic test_step();
    int total = 0;
    for (int s = 0; s < 3; s++) begin
      int pc_cnt = 0, pipe_cnt = 0;
      i_halt_id = 1'b1;
      repeat ($urandom_range(1, 3)) tick();
      issue_cmd(C_STEP);
      i_halt_id = 1'b0;
      for (int c = 0; c < 4; c++) begin
        if (o_pc_en) pc_cnt++;
        if (o_pipe_en) pipe_cnt++;
        tick();
      end
      total += pc_cnt;
      checks++; if (pc_cnt != 1 || pipe_cnt != 1) begin errors++; $display("FAIL step_pulse: got pc=%0d pipe=%0d expected 1 1", pc_cnt, pipe_cnt); end
      checks++; if (o_cmd_ready !== 1'b1 || o_halted !== 1'b0 || o_pc_en !== 1'b0) begin
        errors++; $display("FAIL step_idle_after: got ready=%b halted=%b pc_en=%b expected 1 0 0", o_cmd_ready, o_halted, o_pc_en);
      end
    end
    i_halt_id = 1'b0;
    checks++; if (total != 3) begin errors++; $display("FAIL step_total: got %0d expected 3", total); end
  endtask

  // STEP with HALT in the step cycle drains and halts.
  task automatic test_step_halt();
    int pc_cnt = 0, pipe_cnt = 0;
    issue_cmd(C_STEP);
    i_halt_id = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (o_pc_en) pc_cnt++;
      if (o_pipe_en) pipe_cnt++;
      tick();
      i_halt_id = 1'b0;
    end
    checks++; if (pc_cnt != 1 || pipe_cnt != 1 + int'(DRAIN)) begin
      errors++; $display("FAIL step_halt_enables: got pc=%0d pipe=%0d expected 1 %0d", pc_cnt, pipe_cnt, 1 + int'(DRAIN));
    end
    checks++; if (o_halted !== 1'b1) begin errors++; $display("FAIL step_halt_halted: got %b expected 1", o_halted); end
  endtask

  // RUN/STEP/NOP in HALTED are accepted and discarded.
  task automatic test_halted_ignore();
    logic [1:0] cl [3];
    cl[0] = C_NOP; cl[1] = C_RUN; cl[2] = C_STEP;
    for (int k = 0; k < 3; k++) begin
      checks++; if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL halted_ready: got %b expected 1", o_cmd_ready); end
      issue_cmd(cl[k]);
      tick();
      checks++; if (o_pc_en !== 1'b0 || o_pipe_en !== 1'b0 || o_halted !== 1'b1) begin
        errors++; $display("FAIL halted_ignore: got pc=%b pipe=%b halted=%b expected 0 0 1", o_pc_en, o_pipe_en, o_halted);
      end
    end
  endtask

  // One dump. Optional stall on a word, random ready, or async reset at a word.
  task automatic test_dump(input bit exp_halted, input int stall_word, input int stall_len,
                           input bit rand_ready, input int reset_word);
    logic [NB_DATA-1:0] exp_q [$];
    logic [NB_DATA-1:0] hold_data;
    int widx = 0, stall = 0, gap = 0, gap_bad = 0, hold_bad = 0, en_seen = 0;
    bit hold_pending = 0, aborted = 0, rdy, hs;
    exp_q.push_back(i_pc);
    for (int k = 0; k < int'(N_REGS); k++) exp_q.push_back(regs[k]);
    for (int k = 0; k < int'(MEM_WORDS); k++) exp_q.push_back(mem[k]);
`ifdef DBG_CYCLE_COUNT_EN
    exp_q.push_back(model_cnt);
`endif
    checks++; if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL dump_pre_ready: got %b expected 1", o_cmd_ready); end
    issue_cmd(C_DUMP);
    for (int cyc = 0; cyc < 2000 && widx < int'(N_WORDS) && !aborted; cyc++) begin
      if (o_pc_en || o_pipe_en || o_cmd_ready) en_seen++;
      rdy = 1'b0;
      hs = 1'b0;
      if (o_tx_valid) begin
        if (hold_pending && o_tx_data !== hold_data) hold_bad++;
        if (!hold_pending && gap != 2) gap_bad++;
        if (widx == reset_word) begin
          i_tx_ready = 1'b0;
          #2 i_rst_n = 1'b0;
          #1;
          checks++; if (o_tx_valid !== 1'b0 || o_tx_data !== '0) begin
            errors++; $display("FAIL dump_async_reset: got valid=%b data=%h expected 0 0", o_tx_valid, o_tx_data);
          end
          @(posedge i_clk);
          #3 i_rst_n = 1'b1;
          tick();
          checks++; if (o_cmd_ready !== 1'b1 || o_halted !== 1'b0 || o_tx_valid !== 1'b0) begin
            errors++; $display("FAIL dump_after_reset: got ready=%b halted=%b valid=%b expected 1 0 0", o_cmd_ready, o_halted, o_tx_valid);
          end
          aborted = 1;
        end else begin
          if (widx == stall_word && stall < stall_len) begin
            rdy = 1'b0;
            stall++;
          end else if (rand_ready) begin
            rdy = 1'(($urandom % 2) == 0);
          end else begin
            rdy = 1'b1;
          end
          hs = rdy;
          if (hs) begin
            checks++; if (o_tx_data !== exp_q[widx]) begin
              errors++; $display("FAIL dump_word[%0d]: got %h expected %h", widx, o_tx_data, exp_q[widx]);
            end
            hold_pending = 0;
          end else begin
            hold_pending = 1;
            hold_data = o_tx_data;
          end
          gap = 0;
        end
      end else begin
        if (hold_pending) hold_bad++;
        gap++;
      end
      if (!aborted) begin
        i_tx_ready = rdy;
        tick();
        if (hs) widx++;
      end
    end
    i_tx_ready = 1'b0;
    if (!aborted) begin
      checks++; if (widx != int'(N_WORDS)) begin errors++; $display("FAIL dump_word_count: got %0d expected %0d", widx, N_WORDS); end
      checks++; if (gap_bad != 0 || hold_bad != 0) begin errors++; $display("FAIL dump_handshake: got gap_err=%0d hold_err=%0d expected 0 0", gap_bad, hold_bad); end
      checks++; if (en_seen != 0) begin errors++; $display("FAIL dump_enables: got %0d busy cycles with enable/ready expected 0", en_seen); end
      checks++; if (o_tx_valid !== 1'b0 || o_cmd_ready !== 1'b1 || o_halted !== exp_halted) begin
        errors++; $display("FAIL dump_return: got valid=%b ready=%b halted=%b expected 0 1 %b", o_tx_valid, o_cmd_ready, o_halted, exp_halted);
      end
      checks++; if (o_reg_rd_addr !== '0 || o_mem_rd_addr !== '0) begin
        errors++; $display("FAIL dump_addr_clear: got ra=%h ma=%h expected 0 0", o_reg_rd_addr, o_mem_rd_addr);
      end
    end
  endtask

  initial begin
    fill_pattern();
    test_reset();
    test_run_halt(10);
    i_pc = 32'h0000_0040;
    test_dump(1'b1, -1, 0, 1'b0, -1);
    test_dump(1'b1, 3, 5, 1'b0, -1);
    test_halted_ignore();
    apply_reset();
    test_step();
    test_step_halt();
    test_dump(1'b1, -1, 0, 1'b1, 20);
    test_dump(1'b0, -1, 0, 1'b1, -1);
    for (int it = 0; it < 4; it++) begin
      apply_reset();
      fill_random();
      i_pc = $urandom;
      if (it == 2) test_step_halt();
      else test_run_halt(int'($urandom_range(1, 30)));
      test_dump(1'b1, int'($urandom_range(0, N_WORDS - 1)), int'($urandom_range(1, 6)), 1'b1, -1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
